// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shared_pkg
//  Description : Types and default widths shared by the layer sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package shared_pkg;

    localparam int NUM_LAYERS_DEF = 8;
    localparam int MAX_SEGS_DEF   = 8;
    localparam int ADDR_W_DEF     = 12;
    localparam int SEG_W_DEF      = $clog2(MAX_SEGS_DEF);
    localparam int LAYER_W_DEF    = $clog2(NUM_LAYERS_DEF);
    localparam int DESC_W         = 3 + SEG_W_DEF + ADDR_W_DEF;

    typedef enum logic {
        OP_CONV = 1'b0,
        OP_MAX  = 1'b1
    } op_mode_e;

    // Encoding 2'b11 is reserved and behaves like POST_NONE.
    typedef enum logic [1:0] {
        POST_NONE = 2'd0,
        POST_LRN  = 2'd1,
        POST_PAD  = 2'd2
    } post_op_e;

    typedef logic [3:0] seq_state_e;

    localparam seq_state_e ST_IDLE  = 4'd0;
    localparam seq_state_e ST_CFG   = 4'd1;
    localparam seq_state_e ST_EN    = 4'd2;
    localparam seq_state_e ST_LOAD  = 4'd3;
    localparam seq_state_e ST_SCHED = 4'd4;
    localparam seq_state_e ST_ADV   = 4'd5;
    localparam seq_state_e ST_DIS   = 4'd6;
    localparam seq_state_e ST_POST  = 4'd7;
    localparam seq_state_e ST_NEXT  = 4'd8;

    typedef struct packed {
        post_op_e                post_op;
        op_mode_e                op_mode;
        logic [SEG_W_DEF-1:0]    segs_m1;
        logic [ADDR_W_DEF-1:0]   stride;
    } layer_desc_t;

endpackage
`default_nettype wire

// File: rtl/layer_desc_ram.sv
`default_nettype none
// ============================================================================
//  Module      : layer_desc_ram
//  Description : Layer descriptor register file, one write port, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_desc_ram #(
    parameter int   DEPTH = 8,
    parameter int   WIDTH = 18,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    // Storage is deliberately left unreset; contents are defined by writes only.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Walks the layer descriptor table and drives cfg/load/sched/
//                post-op engines through req/ack handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer
    import shared_pkg::*;
#(
    parameter int   NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int   MAX_SEGS   = MAX_SEGS_DEF,
    parameter int   ADDR_W     = ADDR_W_DEF,
    localparam int  SEG_W      = $clog2(MAX_SEGS),
    localparam int  LAYER_W    = $clog2(NUM_LAYERS),
    localparam int  DESC_WIDTH = 3 + SEG_W + ADDR_W
) (
    input  logic                  core_clk,
    input  logic                  core_rst_n,

    input  logic                  desc_we,
    input  logic [LAYER_W-1:0]    desc_addr,
    input  logic [DESC_WIDTH-1:0] desc_wdata,
    input  logic [LAYER_W-1:0]    num_layers_m1,

    input  logic                  start,
    input  logic                  abort,

    output logic                  cfg_req,
    input  logic                  cfg_ack,
    output logic [LAYER_W-1:0]    cfg_layer,

    output logic                  load_req,
    input  logic                  load_ack,
    output logic [SEG_W-1:0]      load_seg,

    output logic                  sched_req,
    input  logic                  sched_done,
    output logic [ADDR_W-1:0]     ipsum_base_addr,
    output logic [ADDR_W-1:0]     opsum_base_addr,

    output logic                  enable_noc,
    output logic                  enable_lrn,
    output logic                  enable_pad,
    input  logic                  done_post,

    output logic                  busy,
    output logic                  done
);

    seq_state_e              r_state;
    seq_state_e              w_state_nxt;

    logic [LAYER_W-1:0]      r_layer;
    logic [LAYER_W-1:0]      r_last_layer;
    logic [SEG_W-1:0]        r_seg;
    logic [ADDR_W-1:0]       r_base;

    logic                    r_cfg_req;
    logic                    r_load_req;
    logic                    r_sched_req;
    logic                    r_enable_noc;
    logic                    r_enable_lrn;
    logic                    r_enable_pad;
    logic                    r_busy;
    logic                    r_done;

    logic [DESC_WIDTH-1:0]   w_desc;
    logic [ADDR_W-1:0]       w_stride;
    logic [SEG_W-1:0]        w_segs_m1;
    logic                    w_is_conv;
    logic                    w_post_lrn;
    logic                    w_post_pad;
    logic                    w_last_seg;
    logic                    w_last_layer;
    logic                    w_desc_we;
    seq_state_e              w_seg_state;

    // The table is only writable while idle so a running sequence sees a stable descriptor.
    assign w_desc_we = desc_we && (r_state == ST_IDLE);

    layer_desc_ram #(
        .DEPTH (NUM_LAYERS),
        .WIDTH (DESC_WIDTH)
    ) u_desc_ram (
        .clk     (core_clk),
        .i_we    (w_desc_we),
        .i_waddr (desc_addr),
        .i_wdata (desc_wdata),
        .i_raddr (r_layer),
        .o_rdata (w_desc)
    );

    assign w_stride     = w_desc[ADDR_W-1:0];
    assign w_segs_m1    = w_desc[ADDR_W +: SEG_W];
    assign w_is_conv    = (op_mode_e'(w_desc[ADDR_W + SEG_W]) == OP_CONV);
    assign w_post_lrn   = (post_op_e'(w_desc[DESC_WIDTH-1 -: 2]) == POST_LRN);
    assign w_post_pad   = (post_op_e'(w_desc[DESC_WIDTH-1 -: 2]) == POST_PAD);
    assign w_last_seg   = (r_seg == w_segs_m1);
    assign w_last_layer = (r_layer == r_last_layer);
    assign w_seg_state  = w_is_conv ? ST_LOAD : ST_SCHED;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)      w_state_nxt = ST_CFG;
            ST_CFG:   if (cfg_ack)    w_state_nxt = ST_EN;
            ST_EN:                    w_state_nxt = w_seg_state;
            ST_LOAD:  if (load_ack)   w_state_nxt = ST_SCHED;
            ST_SCHED: if (sched_done) w_state_nxt = ST_ADV;
            ST_ADV:                   w_state_nxt = w_last_seg ? ST_DIS : w_seg_state;
            ST_DIS:                   w_state_nxt = (w_post_lrn || w_post_pad) ? ST_POST : ST_NEXT;
            ST_POST:  if (done_post)  w_state_nxt = ST_NEXT;
            ST_NEXT:                  w_state_nxt = w_last_layer ? ST_IDLE : ST_CFG;
            default:                  w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so each req rises with state entry.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            r_state      <= ST_IDLE;
            r_cfg_req    <= 1'b0;
            r_load_req   <= 1'b0;
            r_sched_req  <= 1'b0;
            r_enable_noc <= 1'b0;
            r_enable_lrn <= 1'b0;
            r_enable_pad <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cfg_req    <= (w_state_nxt == ST_CFG);
            r_load_req   <= (w_state_nxt == ST_LOAD);
            r_sched_req  <= (w_state_nxt == ST_SCHED);
            r_enable_noc <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SCHED) ||
                            (w_state_nxt == ST_ADV);
            r_enable_lrn <= (w_state_nxt == ST_POST) && w_post_lrn;
            r_enable_pad <= (w_state_nxt == ST_POST) && w_post_pad;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= !abort && (r_state == ST_NEXT) && w_last_layer;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            r_layer      <= '0;
            r_last_layer <= '0;
            r_seg        <= '0;
            r_base       <= '0;
        end else if (abort) begin
            r_layer      <= '0;
            r_last_layer <= '0;
            r_seg        <= '0;
            r_base       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_last_layer <= num_layers_m1;
                        r_layer      <= '0;
                    end
                end
                ST_CFG: begin
                    if (cfg_ack) begin
                        r_seg  <= '0;
                        r_base <= '0;
                    end
                end
                ST_ADV: begin
                    // Base wraps modulo 2^ADDR_W by construction of the adder width.
                    r_base <= r_base + w_stride;
                    if (!w_last_seg) begin
                        r_seg <= r_seg + SEG_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (!w_last_layer) begin
                        r_layer <= r_layer + LAYER_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_req         = r_cfg_req;
    assign cfg_layer       = r_layer;
    assign load_req        = r_load_req;
    assign load_seg        = r_seg;
    assign sched_req       = r_sched_req;
    assign ipsum_base_addr = r_base;
    assign opsum_base_addr = r_base;
    assign enable_noc      = r_enable_noc;
    assign enable_lrn      = r_enable_lrn;
    assign enable_pad      = r_enable_pad;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// tb_layer_sequencer: directed scenarios with randomized handshake latencies,
// checked against a transaction-level model of the layer walk.
module tb_layer_sequencer;
    import shared_pkg::*;

    localparam int LW = 3;
    localparam int SW = 3;
    localparam int AW = 12;
    localparam int DW = 3 + SW + AW;

    logic          core_clk = 1'b0;
    logic          core_rst_n = 1'b0;
    logic          desc_we = 1'b0;
    logic [LW-1:0] desc_addr = '0;
    logic [DW-1:0] desc_wdata = '0;
    logic [LW-1:0] num_layers_m1 = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_req, load_req, sched_req;
    logic          cfg_ack, load_ack, sched_done, done_post;
    logic [LW-1:0] cfg_layer;
    logic [SW-1:0] load_seg;
    logic [AW-1:0] ipsum_base_addr, opsum_base_addr;
    logic          enable_noc, enable_lrn, enable_pad, busy, done;

    logic [3:0]    acks = '0;
    logic [3:0]    reqs;

    assign cfg_ack    = acks[0];
    assign load_ack   = acks[1];
    assign sched_done = acks[2];
    assign done_post  = acks[3];
    assign reqs       = {enable_lrn | enable_pad, sched_req, load_req, cfg_req};

    layer_sequencer dut (
        .core_clk        (core_clk),
        .core_rst_n      (core_rst_n),
        .desc_we         (desc_we),
        .desc_addr       (desc_addr),
        .desc_wdata      (desc_wdata),
        .num_layers_m1   (num_layers_m1),
        .start           (start),
        .abort           (abort),
        .cfg_req         (cfg_req),
        .cfg_ack         (cfg_ack),
        .cfg_layer       (cfg_layer),
        .load_req        (load_req),
        .load_ack        (load_ack),
        .load_seg        (load_seg),
        .sched_req       (sched_req),
        .sched_done      (sched_done),
        .ipsum_base_addr (ipsum_base_addr),
        .opsum_base_addr (opsum_base_addr),
        .enable_noc      (enable_noc),
        .enable_lrn      (enable_lrn),
        .enable_pad      (enable_pad),
        .done_post       (done_post),
        .busy            (busy),
        .done            (done)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0;
    int n_errors = 0;

    int t_post[8], t_mode[8], t_segs[8], t_stride[8];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    int  wait_cnt[4], wait_tgt[4], dly_fixed[4];
    int  dly_max = 0;
    bit  stray_en = 1'b0;
    logic [3:0] prev_req = '0, prev_ack = '0;
    logic prev_abort = 1'b0;
    int  noc_cycles = 0, pad_cycles = 0, lrn_cycles = 0, done_cnt = 0;

    logic [37:0] all_out;
    assign all_out = {cfg_req, load_req, sched_req, enable_noc, enable_lrn, enable_pad, busy, done,
                      cfg_layer, load_seg, ipsum_base_addr, opsum_base_addr};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int kind, input int layer, input int seg,
                                       input int ip, input int op);
        return 64'({8'(kind), 8'(layer), 8'(seg), 16'(ip), 16'(op)});
    endfunction

    // Responders for the four handshakes plus protocol monitor and event capture.
    always @(negedge core_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (reqs[k]) begin
                acks[k] = (wait_cnt[k] >= wait_tgt[k]);
                wait_cnt[k]++;
            end else begin
                acks[k] = stray_en && ($urandom_range(3, 0) == 0);
                wait_cnt[k] = 0;
                wait_tgt[k] = (dly_fixed[k] >= 0) ? dly_fixed[k] : int'($urandom_range(dly_max, 0));
            end
        end
        if (core_rst_n) begin
            check("enable_onehot", 64'($countones({enable_noc, enable_lrn, enable_pad}) <= 1), 64'd1);
            if (load_req || sched_req) check("noc_during_seg", 64'(enable_noc), 64'd1);
            if (done) check("done_not_busy", 64'(busy), 64'd0);
            for (int k = 0; k < 4; k++) begin
                if (prev_req[k] && !prev_abort) begin
                    if (prev_ack[k]) check($sformatf("req_drop%0d", k), 64'(reqs[k]), 64'd0);
                    else             check($sformatf("req_hold%0d", k), 64'(reqs[k]), 64'd1);
                end
            end
            if (cfg_req && acks[0])   obs_q.push_back(ev(1, int'(cfg_layer), 0, 0, 0));
            if (load_req && acks[1])  obs_q.push_back(ev(2, int'(cfg_layer), int'(load_seg), 0, 0));
            if (sched_req && acks[2]) obs_q.push_back(ev(3, int'(cfg_layer), int'(load_seg),
                                                         int'(ipsum_base_addr), int'(opsum_base_addr)));
            if (reqs[3] && acks[3])   obs_q.push_back(ev(enable_pad ? 5 : 4, int'(cfg_layer), 0, 0, 0));
            if (enable_noc) noc_cycles++;
            if (enable_pad) pad_cycles++;
            if (enable_lrn) lrn_cycles++;
            if (done)       done_cnt++;
        end
        prev_req   = reqs;
        prev_ack   = acks;
        prev_abort = abort;
    end

    task automatic tick();
        @(posedge core_clk);
        #2;
    endtask

    task automatic write_desc(input int addr, input int post, input int mode, input int segs,
                              input int stride);
        layer_desc_t d;
        d.post_op  = post_op_e'(2'(post));
        d.op_mode  = op_mode_e'(1'(mode));
        d.segs_m1  = 3'(segs);
        d.stride   = 12'(stride);
        desc_we    = 1'b1;
        desc_addr  = 3'(addr);
        desc_wdata = d;
        t_post[addr] = post; t_mode[addr] = mode; t_segs[addr] = segs; t_stride[addr] = stride;
        tick();
        desc_we = 1'b0;
    endtask

    // Transaction-level expectation: cfg, then per segment (load if CONV) + sched, then post-op.
    task automatic build_expected(input int n_m1);
        int base;
        exp_q.delete();
        for (int l = 0; l <= n_m1; l++) begin
            exp_q.push_back(ev(1, l, 0, 0, 0));
            base = 0;
            for (int s = 0; s <= t_segs[l]; s++) begin
                if (t_mode[l] == 0) exp_q.push_back(ev(2, l, s, 0, 0));
                exp_q.push_back(ev(3, l, s, base, base));
                base = (base + t_stride[l]) % (1 << AW);
            end
            if (t_post[l] == 1) exp_q.push_back(ev(4, l, 0, 0, 0));
            if (t_post[l] == 2) exp_q.push_back(ev(5, l, 0, 0, 0));
        end
    endtask

    task automatic launch(input int n_m1);
        build_expected(n_m1);
        obs_q.delete();
        done_cnt = 0; noc_cycles = 0; pad_cycles = 0; lrn_cycles = 0;
        num_layers_m1 = 3'(n_m1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input int budget);
        int n = 0;
        int m;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (4) tick();
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_ev_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) begin
            dly_fixed[k] = -1; wait_cnt[k] = 0; wait_tgt[k] = 0;
        end
        repeat (3) @(posedge core_clk);
        #2;
        check("reset_outputs", 64'(all_out), 64'd0);
        core_rst_n = 1'b1;
        tick();
        check("idle_outputs", 64'(all_out), 64'd0);

        // Single CONV layer, immediate acks, with cycle-exact entry timing.
        write_desc(0, 0, 0, 7, 385);
        launch(0);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_cfg_req_after_start", 64'(cfg_req), 64'd1);
        tick();
        check("t1_en_settle", 64'({cfg_req, enable_noc}), 64'd0);
        tick();
        check("t1_noc_on", 64'({enable_noc, load_req}), 64'd3);
        finish_run("t1", 500);
        check("t1_noc_cycles", 64'(noc_cycles), 64'd24);

        // MAX layer with padding post-op lasting five cycles.
        dly_fixed[3] = 4;
        write_desc(0, 2, 1, 0, 100);
        launch(0);
        finish_run("t2", 500);
        check("t2_noc_cycles", 64'(noc_cycles), 64'd2);
        check("t2_pad_cycles", 64'(pad_cycles), 64'd5);
        check("t2_lrn_cycles", 64'(lrn_cycles), 64'd0);
        dly_fixed[3] = -1;

        // Eight mixed layers, random latencies and stray acks.
        dly_max = 10;
        stray_en = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if ($urandom_range(1, 0) == 1) write_desc(l, 1, 0, int'($urandom_range(7, 0)), int'($urandom_range(4095, 0)));
            else                           write_desc(l, 0, 1, int'($urandom_range(7, 0)), int'($urandom_range(4095, 0)));
        end
        launch(7);
        finish_run("t3", 20000);

        // Base address wrap.
        dly_max = 3;
        write_desc(0, 0, 0, 2, 2048);
        launch(0);
        finish_run("t4", 500);

        // Abort in the middle of a scheduler run, then rerun from layer 0.
        write_desc(0, 1, 0, 3, 10);
        write_desc(1, 0, 1, 1, 5);
        dly_fixed[2] = 10;
        launch(1);
        n = 0;
        while (!sched_req && n < 200) begin
            tick();
            n++;
        end
        check("t5_sched_seen", 64'(sched_req), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_abort_outputs", 64'(all_out), 64'd0);
        dly_fixed[2] = -1;
        tick();
        launch(1);
        finish_run("t5_rerun", 2000);

        // start and desc_we while busy have no effect.
        dly_max = 4;
        launch(7);
        repeat (30) tick();
        check("t6_busy_mid", 64'(busy), 64'd1);
        start = 1'b1;
        desc_we = 1'b1;
        desc_addr = 3'd0;
        desc_wdata = '1;
        tick();
        start = 1'b0;
        desc_we = 1'b0;
        finish_run("t6", 20000);
        launch(7);
        finish_run("t6_rerun", 20000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
